// File: rtl/edge_acc_param.sv
// ---------------------------------------------------------------------------
// edge_acc_param
//
// Parametrised Sobel edge-detection / pixel-transfer accelerator. It reads a
// packed 8-bit greyscale image (four pixels per 32-bit word, byte k = pixel
// 4w+k) from a single-port synchronous memory and writes the processed image
// to a second region of the same memory.
//
// Modes (sampled when start is accepted):
//   0 : Sobel magnitude, min(255, |Dx|+|Dy|), with a one-pixel zero border
//   1 : invert, 255-p per byte
//   2 : copy
//   3 : reserved, behaves as copy
//
// Ports:
//   clk     : clock, all state updates on the rising edge
//   reset   : asynchronous, active-high
//   start   : level request from the controller
//   mode    : operating mode, see above
//   addr    : word address to memory (valid while en=1)
//   dataR   : read data, returned the cycle after a read request
//   dataW   : write data (valid while en=1 and we=1)
//   en      : memory request
//   we      : 1 = write, 0 = read
//   busy    : high from the cycle after start is accepted until DONE
//   finish  : high while in DONE
// ---------------------------------------------------------------------------
module edge_acc_param #(
  parameter int IMG_W    = 352,
  parameter int IMG_H    = 288,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 25344,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] addr,
  input  logic [31:0]       dataR,
  output logic [31:0]       dataW,
  output logic              en,
  output logic              we,
  output logic              busy,
  output logic              finish
);

  // Words per image row and the address constants derived from it. All
  // address arithmetic is done at ADDR_W bits so it wraps naturally.
  localparam int WPR = IMG_W / 4;

  localparam logic [ADDR_W-1:0] SRC_A         = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A         = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] ONE_A         = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ROW_A         = ADDR_W'(WPR);
  localparam logic [ADDR_W-1:0] ROW2_A        = ADDR_W'(2 * WPR);
  localparam logic [ADDR_W-1:0] LAST_COL      = ADDR_W'(WPR - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((IMG_H - 3) * WPR);
  localparam logic [ADDR_W-1:0] BOT_BASE      = ADDR_W'((IMG_H - 1) * WPR);
  localparam logic [ADDR_W-1:0] LAST_WORD     = ADDR_W'(WPR * IMG_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR_TOP,
    S_PROC,
    S_CLR_BOT,
    S_XFER,
    S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [1:0]          mode_reg, mode_next;
  // Word column inside the current row (CLR_TOP, PROC, CLR_BOT).
  logic [ADDR_W-1:0]   col_reg, col_next;
  // Word index of row y-1 while processing output row y.
  logic [ADDR_W-1:0]   row_base_reg, row_base_next;
  // Linear word index used by XFER.
  logic [ADDR_W-1:0]   word_reg, word_next;
  // Slot inside a row prime (0..2) or a column (0..3); bit 0 is the
  // read/write toggle in XFER.
  logic [1:0]          phase_reg, phase_next;
  // High during the three priming reads at the start of each Sobel row.
  logic                prime_reg, prime_next;

  // Sliding window: rightmost pixel of column c-1, full column c, and the
  // first two rows of column c+1 (the third row arrives on dataR in the
  // write slot and is used directly).
  logic [2:0][7:0]     prev_reg, prev_next;
  logic [2:0][31:0]    cur_reg, cur_next;
  logic [1:0][31:0]    nxt_reg, nxt_next;

  logic                last_col;
  logic [ADDR_W-1:0]   row_off;
  logic [31:0]         nxt2;
  logic [2:0][47:0]    win_row;
  logic [3:0][7:0]     lane_pix;

  assign last_col = (col_reg == LAST_COL);

  // Row offset for the three read slots: y-1, y, y+1.
  assign row_off = (phase_reg == 2'd1) ? ROW_A :
                   (phase_reg == 2'd2) ? ROW2_A : '0;

  // Beyond the right edge there is no data; the neighbour column is zero.
  assign nxt2 = last_col ? 32'd0 : dataR;

  // Each window row is six bytes: [0] = prev, [1..4] = current word,
  // [5] = first byte of the next word.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [7:0] right_byte;
      if (gi == 2) begin : g_live
        assign right_byte = nxt2[7:0];
      end else begin : g_held
        assign right_byte = nxt_reg[gi][7:0];
      end
      assign win_row[gi] = {right_byte, cur_reg[gi], prev_reg[gi]};
    end
  endgenerate

  // Four Sobel lanes, one per pixel of the output word. Lane gi is centred
  // on window byte gi+1.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [10:0] s11, s12, s13, s21, s23, s31, s32, s33;
      logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg;
      logic [10:0] dx, dy, ax, ay;
      logic [11:0] mag;
      logic        border;

      assign s11 = {3'b000, win_row[0][8*gi      +: 8]};
      assign s12 = {3'b000, win_row[0][8*gi + 8  +: 8]};
      assign s13 = {3'b000, win_row[0][8*gi + 16 +: 8]};
      assign s21 = {3'b000, win_row[1][8*gi      +: 8]};
      assign s23 = {3'b000, win_row[1][8*gi + 16 +: 8]};
      assign s31 = {3'b000, win_row[2][8*gi      +: 8]};
      assign s32 = {3'b000, win_row[2][8*gi + 8  +: 8]};
      assign s33 = {3'b000, win_row[2][8*gi + 16 +: 8]};

      // Each partial sum is at most 1020, so the 11-bit two's-complement
      // difference is exact and its top bit is the sign.
      assign gx_pos = s13 + {s23[9:0], 1'b0} + s33;
      assign gx_neg = s11 + {s21[9:0], 1'b0} + s31;
      assign gy_pos = s11 + {s12[9:0], 1'b0} + s13;
      assign gy_neg = s31 + {s32[9:0], 1'b0} + s33;
      assign dx     = gx_pos - gx_neg;
      assign dy     = gy_pos - gy_neg;
      assign ax     = dx[10] ? (~dx + 11'd1) : dx;
      assign ay     = dy[10] ? (~dy + 11'd1) : dy;
      assign mag    = {1'b0, ax} + {1'b0, ay};

      // Leftmost pixel of word 0 and rightmost pixel of the last word.
      assign border = ((gi == 0) && (col_reg == '0)) || ((gi == 3) && last_col);

      assign lane_pix[gi] = border          ? 8'h00 :
                            (mag > 12'd255) ? 8'hFF : mag[7:0];
    end
  endgenerate

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      mode_reg     <= 2'd0;
      col_reg      <= '0;
      row_base_reg <= '0;
      word_reg     <= '0;
      phase_reg    <= 2'd0;
      prime_reg    <= 1'b0;
      prev_reg     <= '0;
      cur_reg      <= '0;
      nxt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      col_reg      <= col_next;
      row_base_reg <= row_base_next;
      word_reg     <= word_next;
      phase_reg    <= phase_next;
      prime_reg    <= prime_next;
      prev_reg     <= prev_next;
      cur_reg      <= cur_next;
      nxt_reg      <= nxt_next;
    end
  end

  // Next-state and memory-interface logic.
  always_comb begin
    state_next    = state_reg;
    mode_next     = mode_reg;
    col_next      = col_reg;
    row_base_next = row_base_reg;
    word_next     = word_reg;
    phase_next    = phase_reg;
    prime_next    = prime_reg;
    prev_next     = prev_reg;
    cur_next      = cur_reg;
    nxt_next      = nxt_reg;

    en     = 1'b0;
    we     = 1'b0;
    addr   = '0;
    dataW  = 32'd0;
    busy   = (state_reg != S_IDLE) && (state_reg != S_DONE);
    finish = (state_reg == S_DONE);

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          mode_next     = mode;
          col_next      = '0;
          row_base_next = '0;
          word_next     = '0;
          phase_next    = 2'd0;
          prime_next    = 1'b1;
          state_next    = (mode == 2'd0) ? S_CLR_TOP : S_XFER;
        end
      end

      S_CLR_TOP: begin
        en   = 1'b1;
        we   = 1'b1;
        addr = DST_A + col_reg;
        if (last_col) begin
          col_next   = '0;
          state_next = S_PROC;
        end else begin
          col_next = col_reg + ONE_A;
        end
      end

      S_PROC: begin
        if (prime_reg) begin
          // Read column 0 of rows y-1, y, y+1; each result lands one
          // cycle later, the last one in slot 0 of column 0.
          en   = 1'b1;
          addr = SRC_A + row_base_reg + row_off;
          case (phase_reg)
            2'd0:    prev_next   = '0;
            2'd1:    cur_next[0] = dataR;
            2'd2:    cur_next[1] = dataR;
            default: ;
          endcase
          if (phase_reg == 2'd2) begin
            phase_next = 2'd0;
            prime_next = 1'b0;
            col_next   = '0;
          end else begin
            phase_next = phase_reg + 2'd1;
          end
        end else if (phase_reg != 2'd3) begin
          // Fetch column c+1; slots stay idle on the last column.
          if (!last_col) begin
            en   = 1'b1;
            addr = SRC_A + row_base_reg + row_off + col_reg + ONE_A;
          end
          if ((phase_reg == 2'd0) && (col_reg == '0)) cur_next[2] = dataR;
          if (phase_reg == 2'd1) nxt_next[0] = last_col ? 32'd0 : dataR;
          if (phase_reg == 2'd2) nxt_next[1] = last_col ? 32'd0 : dataR;
          phase_next = phase_reg + 2'd1;
        end else begin
          // Write column c of row y, then slide the window one word left.
          en    = 1'b1;
          we    = 1'b1;
          addr  = DST_A + row_base_reg + ROW_A + col_reg;
          dataW = lane_pix;
          for (int r = 0; r < 3; r++) begin
            prev_next[r] = cur_reg[r][31:24];
          end
          cur_next[0] = nxt_reg[0];
          cur_next[1] = nxt_reg[1];
          cur_next[2] = nxt2;
          phase_next  = 2'd0;
          if (last_col) begin
            col_next = '0;
            if (row_base_reg == LAST_ROW_BASE) begin
              state_next = S_CLR_BOT;
            end else begin
              row_base_next = row_base_reg + ROW_A;
              prime_next    = 1'b1;
            end
          end else begin
            col_next = col_reg + ONE_A;
          end
        end
      end

      S_CLR_BOT: begin
        en   = 1'b1;
        we   = 1'b1;
        addr = DST_A + BOT_BASE + col_reg;
        if (last_col) begin
          col_next   = '0;
          state_next = S_DONE;
        end else begin
          col_next = col_reg + ONE_A;
        end
      end

      S_XFER: begin
        en = 1'b1;
        if (!phase_reg[0]) begin
          addr       = SRC_A + word_reg;
          phase_next = 2'd1;
        end else begin
          // Read data from the previous cycle is written straight back.
          we         = 1'b1;
          addr       = DST_A + word_reg;
          dataW      = (mode_reg == 2'd1) ? ~dataR : dataR;
          phase_next = 2'd0;
          if (word_reg == LAST_WORD) begin
            state_next = S_DONE;
          end else begin
            word_next = word_reg + ONE_A;
          end
        end
      end

      S_DONE: begin
        // Wait for start to drop so a held request cannot retrigger.
        if (!start) state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_edge_acc_param.sv
`timescale 1ns/1ps
module tb_edge_acc_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [2:0]  start_v, en_v, we_v, busy_v, finish_v;
  logic [15:0] addr0, addr1, addr2;
  logic [31:0] dw0, dw1, dw2;
  logic [31:0] data_r;

  logic [1:0]  sel;
  logic        en_m, we_m;
  logic [15:0] addr_m;
  logic [31:0] dataw_m;

  logic        ld_en;
  logic [15:0] ld_addr;
  logic [31:0] ld_data;

  logic [31:0] mem [0:1023];
  logic [31:0] exp_w [0:23];
  logic [31:0] xsrc [0:5];
  logic [31:0] xinv [0:5];

  int n_checks = 0;
  int n_errors = 0;
  int viol = 0;

  always #5 clk = ~clk;

  // u_small: 8x4 Sobel; u_xfer: 8x3 transfer; u_mid: 16x6 Sobel at offset bases
  edge_acc_param #(.IMG_W(8), .IMG_H(4), .SRC_BASE(0), .DST_BASE(64), .ADDR_W(16)) u_small (
    .clk(clk), .reset(reset), .start(start_v[0]), .mode(mode), .addr(addr0),
    .dataR(data_r), .dataW(dw0), .en(en_v[0]), .we(we_v[0]), .busy(busy_v[0]),
    .finish(finish_v[0]));

  edge_acc_param #(.IMG_W(8), .IMG_H(3), .SRC_BASE(0), .DST_BASE(64), .ADDR_W(16)) u_xfer (
    .clk(clk), .reset(reset), .start(start_v[1]), .mode(mode), .addr(addr1),
    .dataR(data_r), .dataW(dw1), .en(en_v[1]), .we(we_v[1]), .busy(busy_v[1]),
    .finish(finish_v[1]));

  edge_acc_param #(.IMG_W(16), .IMG_H(6), .SRC_BASE(16), .DST_BASE(256), .ADDR_W(16)) u_mid (
    .clk(clk), .reset(reset), .start(start_v[2]), .mode(mode), .addr(addr2),
    .dataR(data_r), .dataW(dw2), .en(en_v[2]), .we(we_v[2]), .busy(busy_v[2]),
    .finish(finish_v[2]));

  always_comb begin
    en_m = 1'b0; we_m = 1'b0; addr_m = 16'd0; dataw_m = 32'd0;
    case (sel)
      2'd0: begin en_m = en_v[0]; we_m = we_v[0]; addr_m = addr0; dataw_m = dw0; end
      2'd1: begin en_m = en_v[1]; we_m = we_v[1]; addr_m = addr1; dataw_m = dw1; end
      2'd2: begin en_m = en_v[2]; we_m = we_v[2]; addr_m = addr2; dataw_m = dw2; end
      default: ;
    endcase
  end

  function automatic bit in_region(input logic [1:0] s, input logic [15:0] a);
    int lo_s, lo_d, n;
    case (s)
      2'd0:    begin lo_s = 0;  lo_d = 64;  n = 8;  end
      2'd1:    begin lo_s = 0;  lo_d = 64;  n = 6;  end
      default: begin lo_s = 16; lo_d = 256; n = 24; end
    endcase
    return ((int'(a) >= lo_s) && (int'(a) < lo_s + n)) ||
           ((int'(a) >= lo_d) && (int'(a) < lo_d + n));
  endfunction

  // Synchronous single-port memory: read data appears the next cycle.
  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr[9:0]] <= ld_data;
    end else if (en_m) begin
      if (we_m) mem[addr_m[9:0]] <= dataw_m;
      else      data_r <= mem[addr_m[9:0]];
    end
    if (en_m && !in_region(sel, addr_m)) viol <= viol + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = 16'(a); ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic fill(input int lo, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) poke(lo + i, d);
  endtask

  task automatic check_dst(input string tag, input int lo, input int n);
    for (int i = 0; i < n; i++)
      check_val($sformatf("%s w%0d", tag, i), mem[lo + i], exp_w[i]);
  endtask

  task automatic run_dut(input logic [1:0] idx, input logic [1:0] m, input int exp_cyc,
                         input string tag, input bit hold);
    int n;
    sel = idx; mode = m; start_v[idx] = 1'b1;
    @(posedge clk); #1;
    check_val({tag, " busy"}, {31'd0, busy_v[idx]}, 32'd1);
    if (!hold) start_v[idx] = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!finish_v[idx] && n < 2000);
    check_val({tag, " cycles"}, 32'(n), 32'(exp_cyc));
    $display("run %s: dut %0d mode %0d finish after %0d cycles", tag, idx, m, n);
    if (!hold) begin
      @(posedge clk); #1;
      check_val({tag, " finish clear"}, {31'd0, finish_v[idx]}, 32'd0);
    end
  endtask

  function automatic int pix(input int x, input int y);
    return (x * 7 + y * 11 + ((x * y * 29) & 63)) & 255;
  endfunction

  function automatic int gold(input int x, input int y);
    int dx, dy, m;
    if (x == 0 || x == 15 || y == 0 || y == 5) return 0;
    dx = (pix(x+1,y-1) + 2*pix(x+1,y) + pix(x+1,y+1)) - (pix(x-1,y-1) + 2*pix(x-1,y) + pix(x-1,y+1));
    dy = (pix(x-1,y-1) + 2*pix(x,y-1) + pix(x+1,y-1)) - (pix(x-1,y+1) + 2*pix(x,y+1) + pix(x+1,y+1));
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    m = dx + dy;
    return (m > 255) ? 255 : m;
  endfunction

  task automatic load_edge_image();
    for (int y = 0; y < 4; y++) begin
      poke(2*y,     32'h00000000);
      poke(2*y + 1, 32'hFFFFFFFF);
    end
  endtask

  task automatic set_edge_expect();
    exp_w[0] = 32'h0; exp_w[1] = 32'h0;
    exp_w[2] = 32'hFF000000; exp_w[3] = 32'h000000FF;
    exp_w[4] = 32'hFF000000; exp_w[5] = 32'h000000FF;
    exp_w[6] = 32'h0; exp_w[7] = 32'h0;
  endtask

  task automatic load_mid();
    for (int y = 0; y < 6; y++)
      for (int w = 0; w < 4; w++) begin
        poke(16 + 4*y + w, {8'(pix(4*w+3,y)), 8'(pix(4*w+2,y)), 8'(pix(4*w+1,y)), 8'(pix(4*w,y))});
        exp_w[4*y + w] = {8'(gold(4*w+3,y)), 8'(gold(4*w+2,y)), 8'(gold(4*w+1,y)), 8'(gold(4*w,y))};
      end
  endtask

  initial begin
    xsrc = '{32'h00FF1080, 32'h11111111, 32'h22222222, 32'h12345678, 32'h89ABCDEF, 32'hFFFFFFFF};
    xinv = '{32'hFF00EF7F, 32'hEEEEEEEE, 32'hDDDDDDDD, 32'hEDCBA987, 32'h76543210, 32'h00000000};
    reset = 1'b1; start_v = 3'b000; mode = 2'd0; sel = 2'd0;
    ld_en = 1'b0; ld_addr = 16'd0; ld_data = 32'd0;
    #1;
    check_val("rst en",     {31'd0, en_v[0]},     32'd0);
    check_val("rst we",     {31'd0, we_v[0]},     32'd0);
    check_val("rst busy",   {31'd0, busy_v[0]},   32'd0);
    check_val("rst finish", {31'd0, finish_v[0]}, 32'd0);
    check_val("rst addr",   {16'd0, addr0},       32'd0);
    check_val("rst dataW",  dw0,                  32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Flat 0x80 image: all destination words zero.
    fill(0, 8, 32'h80808080);
    fill(64, 8, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) exp_w[i] = 32'h0;
    run_dut(2'd0, 2'd0, 26, "flat", 1'b0);
    check_dst("flat", 64, 8);

    // Vertical edge between pixels 3 and 4.
    load_edge_image();
    fill(64, 8, 32'hDEADBEEF);
    set_edge_expect();
    run_dut(2'd0, 2'd0, 26, "vedge", 1'b0);
    check_dst("vedge", 64, 8);

    // Invert on 8x3.
    for (int i = 0; i < 6; i++) poke(i, xsrc[i]);
    fill(64, 6, 32'hDEADBEEF);
    for (int i = 0; i < 6; i++) exp_w[i] = xinv[i];
    run_dut(2'd1, 2'd1, 12, "invert", 1'b0);
    check_dst("invert", 64, 6);

    // Copy, then the reserved mode which behaves as copy.
    for (int m = 2; m < 4; m++) begin
      fill(64, 6, 32'hDEADBEEF);
      for (int i = 0; i < 6; i++) exp_w[i] = xsrc[i];
      run_dut(2'd1, 2'(m), 12, $sformatf("copy%0d", m), 1'b0);
      check_dst($sformatf("copy%0d", m), 64, 6);
    end

    // 16x6 image against the pixel-domain model.
    load_mid();
    fill(256, 24, 32'hDEADBEEF);
    run_dut(2'd2, 2'd0, 84, "mid", 1'b0);
    check_dst("mid", 256, 24);

    // Reset in the middle of PROC, then a clean rerun.
    fill(256, 24, 32'hDEADBEEF);
    sel = 2'd2; mode = 2'd0; start_v[2] = 1'b1;
    @(posedge clk); #1;
    start_v[2] = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_val("midrst en",     {31'd0, en_v[2]},     32'd0);
    check_val("midrst busy",   {31'd0, busy_v[2]},   32'd0);
    check_val("midrst finish", {31'd0, finish_v[2]}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset applied mid-run on dut 2");
    run_dut(2'd2, 2'd0, 84, "after rst", 1'b0);
    check_dst("after rst", 256, 24);

    // start held through DONE.
    load_edge_image();
    fill(64, 8, 32'hDEADBEEF);
    set_edge_expect();
    run_dut(2'd0, 2'd0, 26, "held", 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_val($sformatf("held hold%0d busy/en/finish", i),
                {29'd0, busy_v[0], en_v[0], finish_v[0]}, 32'd1);
    end
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    check_val("held drop finish", {31'd0, finish_v[0]}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val("held no rerun busy", {31'd0, busy_v[0]}, 32'd0);
    fill(64, 8, 32'hDEADBEEF);
    run_dut(2'd0, 2'd0, 26, "repulse", 1'b0);
    check_dst("repulse", 64, 8);

    check_val("region violations", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
